// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS main controller and the datapath.
// The controller is the master: it reads opcode/mem_ready and drives every
// datapath strobe and mux select.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       alu_func_sel;
   logic [1:0] pc_source;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             alu_func_sel, pc_source
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             alu_func_sel, pc_source
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core. Sequences FETCH / DECODE /
// EXEC / MEM / WB over the shared ALU and memory port, stalls on mem_ready,
// traps on illegal opcodes and counts retired instructions.
module multicycle_control #(
   parameter bit TRAP_ON_ILLEGAL = 1'b1,
   parameter int CNT_W           = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_control_if.master   bus,
   output logic                   illegal_op,
   output logic [CNT_W-1:0]       retired,
   output logic [3:0]             state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      I_EXEC   = 4'd10,
      I_WB     = 4'd11,
      TRAP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             illegal_op_reg;

   logic is_r;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_j;
   logic is_addi;
   logic is_logic_imm;

   // Opcode class decode; IR is stable from DECODE onward
   always_comb begin
      is_r         = (bus.opcode == OP_R);
      is_lw        = (bus.opcode == OP_LW);
      is_sw        = (bus.opcode == OP_SW);
      is_beq       = (bus.opcode == OP_BEQ);
      is_j         = (bus.opcode == OP_J);
      is_addi      = (bus.opcode == OP_ADDI);
      is_logic_imm = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
   end

   // State sequencing, retired-instruction counting and the illegal-op flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= FETCH;
         retired_reg    <= '0;
         illegal_op_reg <= 1'b0;
      end else begin
         illegal_op_reg <= 1'b0;
         case (state_reg)
            FETCH: begin
               if (bus.mem_ready) begin
                  state_reg <= DECODE;
               end
            end
            DECODE: begin
               if (is_lw || is_sw) begin
                  state_reg <= MEM_ADDR;
               end else if (is_r) begin
                  state_reg <= R_EXEC;
               end else if (is_beq) begin
                  state_reg <= BRANCH;
               end else if (is_j) begin
                  state_reg <= JUMP;
               end else if (is_addi || is_logic_imm) begin
                  state_reg <= I_EXEC;
               end else begin
                  // illegal_op rises together with the TRAP state
                  state_reg      <= TRAP;
                  illegal_op_reg <= 1'b1;
               end
            end
            MEM_ADDR: begin
               state_reg <= is_lw ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
               if (bus.mem_ready) begin
                  state_reg <= MEM_WB;
               end
            end
            MEM_WB: begin
               state_reg   <= FETCH;
               retired_reg <= retired_reg + CNT_ONE;
            end
            MEM_WR: begin
               if (bus.mem_ready) begin
                  state_reg   <= FETCH;
                  retired_reg <= retired_reg + CNT_ONE;
               end
            end
            R_EXEC: begin
               state_reg <= R_WB;
            end
            R_WB: begin
               state_reg   <= FETCH;
               retired_reg <= retired_reg + CNT_ONE;
            end
            BRANCH: begin
               state_reg   <= FETCH;
               retired_reg <= retired_reg + CNT_ONE;
            end
            JUMP: begin
               state_reg   <= FETCH;
               retired_reg <= retired_reg + CNT_ONE;
            end
            I_EXEC: begin
               state_reg <= I_WB;
            end
            I_WB: begin
               state_reg   <= FETCH;
               retired_reg <= retired_reg + CNT_ONE;
            end
            TRAP: begin
               // Sticky trap holds the flag; non-sticky mode gives a one-cycle
               // pulse and resumes fetching without counting the instruction
               if (TRAP_ON_ILLEGAL) begin
                  illegal_op_reg <= 1'b1;
               end else begin
                  state_reg <= FETCH;
               end
            end
            default: begin
               state_reg <= FETCH;
            end
         endcase
      end
   end

   // Datapath controls are a pure decode of the current state, forced low
   // while reset is asserted so no write strobe can pulse during reset
   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.alu_func_sel  = 1'b0;
      bus.pc_source     = 2'b00;
      if (rst_n) begin
         case (state_reg)
            FETCH: begin
               // PC+4 through the ALU; IR and PC only load when the read lands
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
               // Speculative branch target into ALUOut
               bus.alu_src_b = 2'b11;
            end
            MEM_ADDR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
            end
            MEM_RD: begin
               bus.mem_read = 1'b1;
               bus.i_or_d   = 1'b1;
            end
            MEM_WB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
               bus.mem_write = 1'b1;
               bus.i_or_d    = 1'b1;
            end
            R_EXEC: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'b10;
            end
            R_WB: begin
               bus.reg_dst   = 1'b1;
               bus.reg_write = 1'b1;
            end
            BRANCH: begin
               bus.alu_src_a     = 1'b1;
               bus.alu_op        = 2'b01;
               bus.pc_write_cond = 1'b1;
               bus.pc_source     = 2'b01;
            end
            JUMP: begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'b10;
            end
            I_EXEC: begin
               // andi/ori reuse the function-field decoder fed with the opcode
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
               if (is_logic_imm) begin
                  bus.alu_op       = 2'b10;
                  bus.alu_func_sel = 1'b1;
               end
            end
            I_WB: begin
               bus.reg_write = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign illegal_op = illegal_op_reg;
   assign retired    = retired_reg;
   assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. The driver applies opcode and
// mem_ready once per cycle and queues the expected state, control word and
// retired count; a negedge monitor pops and compares. A second instance with
// non-sticky traps shares the stimulus for the illegal-opcode pulse checks.
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   typedef struct {
      logic [3:0]  st;
      logic [17:0] ctrl;
      logic [31:0] ret;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode_drv;
   logic        mem_ready_drv;

   logic        illegal_op;
   logic [31:0] retired;
   logic [3:0]  state;
   logic        illegal_op0;
   logic [31:0] retired0;
   logic [3:0]  state0;

   int          checks;
   int          errors;
   logic [31:0] exp_ret;
   exp_t        sb[$];

   multicycle_control_if bus ();
   multicycle_control_if bus0 ();

   assign bus.opcode     = opcode_drv;
   assign bus.mem_ready  = mem_ready_drv;
   assign bus0.opcode    = opcode_drv;
   assign bus0.mem_ready = mem_ready_drv;

   multicycle_control #(.TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .illegal_op (illegal_op),
      .retired    (retired),
      .state      (state)
   );

   multicycle_control #(.TRAP_ON_ILLEGAL(1'b0), .CNT_W(32)) dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus0),
      .illegal_op (illegal_op0),
      .retired    (retired0),
      .state      (state0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [17:0] obs_ctrl;
   assign obs_ctrl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                      bus.alu_func_sel, bus.pc_source, illegal_op};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected control word for a state, taken from the controller's state table
   function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic mr);
      logic pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rwr, srca, fsel, ill;
      logic [1:0] srcb, aop, pcs;
      {pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rwr, srca, fsel, ill} = '0;
      srcb = 2'b00;
      aop  = 2'b00;
      pcs  = 2'b00;
      case (st)
         4'd0:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
         4'd1:  srcb = 2'b11;
         4'd2:  begin srca = 1'b1; srcb = 2'b10; end
         4'd3:  begin mrd = 1'b1; iod = 1'b1; end
         4'd4:  begin rwr = 1'b1; m2r = 1'b1; end
         4'd5:  begin mwr = 1'b1; iod = 1'b1; end
         4'd6:  begin srca = 1'b1; aop = 2'b10; end
         4'd7:  begin rdst = 1'b1; rwr = 1'b1; end
         4'd8:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
         4'd9:  begin pcw = 1'b1; pcs = 2'b10; end
         4'd10: begin
            srca = 1'b1;
            srcb = 2'b10;
            if (op == OP_ANDI || op == OP_ORI) begin
               aop  = 2'b10;
               fsel = 1'b1;
            end
         end
         4'd11: rwr = 1'b1;
         4'd12: ill = 1'b1;
         default: ;
      endcase
      return {pcw, pcwc, iod, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, fsel, pcs, ill};
   endfunction

   // One clock cycle of stimulus plus its expected observation
   task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] st);
      exp_t e;
      @(posedge clk);
      #1;
      opcode_drv    = op;
      mem_ready_drv = mr;
      e.st   = st;
      e.ctrl = exp_ctrl(st, op, mr);
      e.ret  = exp_ret;
      sb.push_back(e);
   endtask

   // Full instruction: wf wait cycles in FETCH, wm wait cycles in MEM_RD/MEM_WR
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      int cyc;
      cyc = 0;
      for (int i = 0; i < wf; i++) begin step(op, 1'b0, 4'd0); cyc++; end
      step(op, 1'b1, 4'd0); cyc++;
      step(op, 1'b1, 4'd1); cyc++;
      case (op)
         OP_LW: begin
            step(op, 1'b1, 4'd2); cyc++;
            for (int i = 0; i < wm; i++) begin step(op, 1'b0, 4'd3); cyc++; end
            step(op, 1'b1, 4'd3); cyc++;
            step(op, 1'b1, 4'd4); cyc++;
         end
         OP_SW: begin
            step(op, 1'b1, 4'd2); cyc++;
            for (int i = 0; i < wm; i++) begin step(op, 1'b0, 4'd5); cyc++; end
            step(op, 1'b1, 4'd5); cyc++;
         end
         OP_R: begin
            step(op, 1'b1, 4'd6); cyc++;
            step(op, 1'b1, 4'd7); cyc++;
         end
         OP_BEQ: begin step(op, 1'b1, 4'd8); cyc++; end
         OP_J:   begin step(op, 1'b1, 4'd9); cyc++; end
         default: begin
            step(op, 1'b1, 4'd10); cyc++;
            step(op, 1'b1, 4'd11); cyc++;
         end
      endcase
      exp_ret = exp_ret + 32'd1;
      $display("instr op=%b fetch_wait=%0d mem_wait=%0d cycles=%0d", op, wf, wm, cyc);
   endtask

   // Scoreboard monitor: compare on the falling edge, away from state updates
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && sb.size() != 0) begin
         e = sb.pop_front();
         check("state", 64'(state), 64'(e.st));
         check("ctrl", 64'(obs_ctrl), 64'(e.ctrl));
         check("retired", 64'(retired), 64'(e.ret));
      end
   end

   initial begin
      checks        = 0;
      errors        = 0;
      exp_ret       = 32'd0;
      rst_n         = 1'b0;
      opcode_drv    = 6'd0;
      mem_ready_drv = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", 64'(obs_ctrl), 64'd0);
      check("rst_retired", 64'(retired), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_state", 64'(state), 64'd0);
      check("rel_mem_read", 64'(bus.mem_read), 64'd1);
      check("rel_retired", 64'(retired), 64'd0);

      // Main instruction mix
      run_instr(OP_LW,   2, 1);
      run_instr(OP_R,    0, 0);
      run_instr(OP_ANDI, 0, 0);
      run_instr(OP_ORI,  0, 0);
      run_instr(OP_ADDI, 0, 0);
      run_instr(OP_BEQ,  0, 0);
      run_instr(OP_J,    0, 0);
      run_instr(OP_SW,   1, 2);
      run_instr(OP_LW,   0, 0);

      // Reset in the middle of a stalled store
      step(OP_SW, 1'b1, 4'd0);
      step(OP_SW, 1'b1, 4'd1);
      step(OP_SW, 1'b1, 4'd2);
      step(OP_SW, 1'b0, 4'd5);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", 64'(obs_ctrl), 64'd0);
      check("midrst_state", 64'(state), 64'd0);
      check("midrst_retired", 64'(retired), 64'd0);
      check("midrst_retired0", 64'(retired0), 64'd0);
      exp_ret = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel2_state", 64'(state), 64'd0);
      check("rel2_mem_read", 64'(bus.mem_read), 64'd1);

      run_instr(OP_R,   0, 0);
      run_instr(OP_ADDI, 1, 0);

      // Illegal opcode: sticky trap on dut, one-cycle pulse on dut0
      step(OP_BAD, 1'b1, 4'd0);
      step(OP_BAD, 1'b1, 4'd1);
      step(OP_BAD, 1'b1, 4'd12);
      check("trap0_state", 64'(state0), 64'd12);
      check("trap0_illegal", 64'(illegal_op0), 64'd1);
      step(OP_BAD, 1'b1, 4'd12);
      check("trap0_exit_state", 64'(state0), 64'd0);
      check("trap0_exit_illegal", 64'(illegal_op0), 64'd0);
      check("trap0_retired", 64'(retired0), 64'(exp_ret));
      for (int i = 0; i < 18; i++) step(OP_BAD, 1'b1, 4'd12);
      $display("instr op=%b trapped for 20 cycles retired=%0d", OP_BAD, exp_ret);

      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("final_rst_illegal", 64'(illegal_op), 64'd0);
      check("final_rst_state", 64'(state), 64'd0);
      check("final_rst_retired", 64'(retired), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
